// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define SERIAL_PARITY_RX_PARITY_EN to include the parity bit and PARITY state.
module serial_parity_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             parity_err,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_t;
`endif

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             done;
`ifdef SERIAL_PARITY_RX_PARITY_EN
    logic             par_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (in_valid) begin
            unique case (state)
                IDLE:   if (!in_bit) nxt = DATA;
`ifdef SERIAL_PARITY_RX_PARITY_EN
                DATA:   if (cnt == LAST) nxt = PARITY;
                PARITY: nxt = STOP;
`else
                DATA:   if (cnt == LAST) nxt = STOP;
`endif
                // A 0 stop bit returns to IDLE; it is never taken as the next start bit.
                STOP:   nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        done = in_valid && (state == STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
`ifdef SERIAL_PARITY_RX_PARITY_EN
            par_acc <= 1'b0;
`endif
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    cnt <= '0;
`ifdef SERIAL_PARITY_RX_PARITY_EN
                    par_acc <= 1'b0;
`endif
                end
                DATA: begin
                    for (int i = 0; i < WIDTH; i++)
                        if (cnt == CW'(i)) shreg[i] <= in_bit;
                    cnt <= cnt + CW'(1);
`ifdef SERIAL_PARITY_RX_PARITY_EN
                    par_acc <= par_acc ^ in_bit;
`endif
                end
`ifdef SERIAL_PARITY_RX_PARITY_EN
                PARITY: par_acc <= par_acc ^ in_bit;
`endif
                default: ;
            endcase
        end
    end

    // Result registers: flags are only ever high alongside the out_valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= done;
            frame_err <= done & ~in_bit;
            if (done) out_data <= shreg;
        end
    end

`ifdef SERIAL_PARITY_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= done & par_acc;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
